// File: rtl/snoop_arb_pkg.sv
// Shared definitions for the snoop arbiter root controller.
package snoop_arb_pkg;

    localparam int TAG_SZ_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2,
        DROP  = 2'd3
    } state_e;

endpackage

// File: rtl/snoop_arb_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle load the value one.
module sat_counter
    import snoop_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base;

    // Next value: optional clear, then increment unless already all-ones.
    always_comb begin
        base    = clr ? '0 : count_q;
        count_d = base;
        if (inc && (base != '1)) begin
            count_d = base + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/snoop_arb_ctrl.sv
// Root consumer of the snoop arbiter tag tree: takes the winning core tag,
// holds that grant for one snooped packet, steers beats to the core and
// reports completion. Optionally discards packets that arrive with no grant.
module snoop_arb_ctrl
    import snoop_arb_pkg::*;
#(
    parameter int TAG_SZ         = TAG_SZ_DEF,
    parameter int LEN_SZ         = 16,
    parameter int DROP_WHEN_NONE = 0,
    parameter int DROP_CNT_SZ    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TAG_SZ-1:0]      tag,
    input  logic                   rdy,
    output logic                   ack,
    input  logic                   sn_vld,
    input  logic                   sn_last,
    output logic                   sn_rdy,
    output logic [TAG_SZ-1:0]      sel_tag,
    output logic                   sel_vld,
    output logic                   wr_en,
    output logic                   done,
    output logic [TAG_SZ-1:0]      done_tag,
    output logic [LEN_SZ-1:0]      done_len,
    output logic [DROP_CNT_SZ-1:0] drop_cnt
);

    state_e              state_q, state_d;
    logic [TAG_SZ-1:0]   sel_tag_q;
    logic                done_q;
    logic [TAG_SZ-1:0]   done_tag_q;
    logic [LEN_SZ-1:0]   done_len_q;
    logic [LEN_SZ-1:0]   beat_cnt;
    logic [LEN_SZ-1:0]   len_next;
    logic                cnt_clr, cnt_inc, drop_inc, fin;

    // Next-state and handshake decode; a grant is only taken in IDLE so it
    // can never start in the middle of a packet.
    always_comb begin
        state_d  = state_q;
        ack      = 1'b0;
        sn_rdy   = 1'b0;
        sel_vld  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        drop_inc = 1'b0;
        fin      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rdy) begin
                    ack     = 1'b1;
                    state_d = ARMED;
                end else if (DROP_WHEN_NONE != 0) begin
                    sn_rdy = 1'b1;
                    if (sn_vld) begin
                        if (sn_last) drop_inc = 1'b1;
                        else         state_d  = DROP;
                    end
                end
            end
            ARMED: begin
                sel_vld = 1'b1;
                sn_rdy  = 1'b1;
                if (sn_vld) begin
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                    if (sn_last) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                sel_vld = 1'b1;
                sn_rdy  = 1'b1;
                if (sn_vld) begin
                    cnt_inc = 1'b1;
                    if (sn_last) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                sn_rdy = 1'b1;
                if (sn_vld && sn_last) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Length reported at completion includes the last beat; first beat
    // (ARMED) always counts as one.
    always_comb begin
        if (state_q == ARMED)   len_next = LEN_SZ'(1);
        else if (beat_cnt == '1) len_next = beat_cnt;
        else                     len_next = beat_cnt + LEN_SZ'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Grant tag capture; held through IDLE until the next ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     sel_tag_q <= '0;
        else if (ack) sel_tag_q <= tag;
    end

    // Registered completion pulse with its tag and length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q     <= 1'b0;
            done_tag_q <= '0;
            done_len_q <= '0;
        end else begin
            done_q <= fin;
            if (fin) begin
                done_tag_q <= sel_tag_q;
                done_len_q <= len_next;
            end
        end
    end

    sat_counter #(.WIDTH(LEN_SZ)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (beat_cnt)
    );

    sat_counter #(.WIDTH(DROP_CNT_SZ)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    assign wr_en    = sn_vld && sn_rdy && sel_vld;
    assign sel_tag  = sel_tag_q;
    assign done     = done_q;
    assign done_tag = done_tag_q;
    assign done_len = done_len_q;

endmodule

// File: tb/tb_snoop_arb_ctrl.sv
// Bench for snoop_arb_ctrl: three instances (backpressure, drop mode, and a
// 4-bit beat counter) share one stimulus stream and are each checked every
// cycle against a per-instance packet-level model.
module tb_snoop_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] tag;
    logic       rdy, sn_vld, sn_last;

    logic        ack0, srdy0, sv0, wr0, dn0;
    logic [4:0]  st0, dt0;
    logic [15:0] dl0;
    logic [31:0] dc0;
    logic        ack1, srdy1, sv1, wr1, dn1;
    logic [4:0]  st1, dt1;
    logic [15:0] dl1;
    logic [31:0] dc1;
    logic        ack2, srdy2, sv2, wr2, dn2;
    logic [4:0]  st2, dt2;
    logic [3:0]  dl2;
    logic [31:0] dc2;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    snoop_arb_ctrl u0 (
        .clk(clk), .rst(rst), .tag(tag), .rdy(rdy), .ack(ack0),
        .sn_vld(sn_vld), .sn_last(sn_last), .sn_rdy(srdy0),
        .sel_tag(st0), .sel_vld(sv0), .wr_en(wr0), .done(dn0),
        .done_tag(dt0), .done_len(dl0), .drop_cnt(dc0));

    snoop_arb_ctrl #(.DROP_WHEN_NONE(1)) u1 (
        .clk(clk), .rst(rst), .tag(tag), .rdy(rdy), .ack(ack1),
        .sn_vld(sn_vld), .sn_last(sn_last), .sn_rdy(srdy1),
        .sel_tag(st1), .sel_vld(sv1), .wr_en(wr1), .done(dn1),
        .done_tag(dt1), .done_len(dl1), .drop_cnt(dc1));

    snoop_arb_ctrl #(.LEN_SZ(4)) u2 (
        .clk(clk), .rst(rst), .tag(tag), .rdy(rdy), .ack(ack2),
        .sn_vld(sn_vld), .sn_last(sn_last), .sn_rdy(srdy2),
        .sel_tag(st2), .sel_vld(sv2), .wr_en(wr2), .done(dn2),
        .done_tag(dt2), .done_len(dl2), .drop_cnt(dc2));

    // Packet-level model: does a grant exist, is a packet being discarded,
    // how many beats has the granted packet carried so far.
    typedef struct {
        bit         granted;
        bit         dropping;
        logic [4:0] gtag;
        int         beats;
        int         drops;
        bit         done;
        logic [4:0] dtag;
        int         dlen;
    } mdl_t;

    typedef struct {
        logic        ack, srdy, sv, wr, dn;
        logic [4:0]  st, dt;
        logic [15:0] dl;
        logic [31:0] dc;
    } obs_t;

    mdl_t m [3];
    int   dm   [3] = '{0, 1, 0};
    int   lmax [3] = '{65535, 65535, 15};

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.granted = 0; r.dropping = 0; r.gtag = '0; r.beats = 0;
        r.drops = 0; r.done = 0; r.dtag = '0; r.dlen = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, int i);
        mdl_t n = s;
        bit   idle = !s.granted && !s.dropping;
        n.done = 0;
        if (idle && rdy) begin
            n.granted = 1; n.gtag = tag; n.beats = 0;
        end else if (idle && dm[i] != 0 && sn_vld) begin
            if (sn_last) n.drops = s.drops + 1;
            else         n.dropping = 1;
        end else if (s.dropping && sn_vld && sn_last) begin
            n.dropping = 0; n.drops = s.drops + 1;
        end else if (s.granted && sn_vld) begin
            n.beats = s.beats + 1;
            if (sn_last) begin
                n.done = 1; n.dtag = s.gtag; n.granted = 0;
                n.dlen = (n.beats > lmax[i]) ? lmax[i] : n.beats;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) m[i] <= mdl_reset();
            else      m[i] <= mdl_step(m[i], i);
        end
    end

    function automatic obs_t get_obs(int i);
        obs_t o;
        case (i)
            0: begin o.ack = ack0; o.srdy = srdy0; o.sv = sv0; o.wr = wr0; o.dn = dn0;
                     o.st = st0; o.dt = dt0; o.dl = dl0; o.dc = dc0; end
            1: begin o.ack = ack1; o.srdy = srdy1; o.sv = sv1; o.wr = wr1; o.dn = dn1;
                     o.st = st1; o.dt = dt1; o.dl = dl1; o.dc = dc1; end
            default: begin o.ack = ack2; o.srdy = srdy2; o.sv = sv2; o.wr = wr2; o.dn = dn2;
                     o.st = st2; o.dt = dt2; o.dl = {12'b0, dl2}; o.dc = dc2; end
        endcase
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            obs_t o = get_obs(i);
            mdl_t s = m[i];
            bit idle = !s.granted && !s.dropping;
            bit e_srdy = s.granted || s.dropping || (idle && !rdy && dm[i] != 0);
            chk($sformatf("u%0d.ack", i),      32'(o.ack),  32'(idle && rdy));
            chk($sformatf("u%0d.sn_rdy", i),   32'(o.srdy), 32'(e_srdy));
            chk($sformatf("u%0d.sel_vld", i),  32'(o.sv),   32'(s.granted));
            chk($sformatf("u%0d.wr_en", i),    32'(o.wr),   32'(sn_vld && e_srdy && s.granted));
            chk($sformatf("u%0d.sel_tag", i),  32'(o.st),   32'(s.gtag));
            chk($sformatf("u%0d.done", i),     32'(o.dn),   32'(s.done));
            chk($sformatf("u%0d.done_tag", i), 32'(o.dt),   32'(s.dtag));
            chk($sformatf("u%0d.done_len", i), 32'(o.dl),   32'(s.dlen));
            chk($sformatf("u%0d.drop_cnt", i), o.dc,        32'(s.drops));
        end
    endtask

    task automatic drive(logic r, logic [4:0] t, logic v, logic l);
        @(negedge clk);
        rdy = r; tag = t; sn_vld = v; sn_last = l;
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b0; tag = '0; sn_vld = 1'b0; sn_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset.sel_vld", 32'(sv0), 0);
        @(negedge clk);
        rst = 1'b1;

        // Grant tag 7 then a gapless 4-beat packet.
        drive(1, 5'd7, 0, 0);
        chk("grant.ack", 32'(ack0), 1);
        drive(0, 5'd0, 0, 0);
        chk("grant.sel_vld", 32'(sv0), 1);
        chk("grant.sel_tag", 32'(st0), 7);
        for (int b = 0; b < 4; b++) begin
            drive(0, 5'd0, 1, logic'(b == 3));
            chk("pkt4.wr_en", 32'(wr0), 1);
        end
        drive(0, 5'd0, 0, 0);
        chk("pkt4.done", 32'(dn0), 1);
        chk("pkt4.done_tag", 32'(dt0), 7);
        chk("pkt4.done_len", 32'(dl0), 4);

        // Single-beat packet on tag 3; re-grant during the done cycle.
        drive(1, 5'd3, 0, 0);
        drive(0, 5'd0, 1, 1);
        drive(1, 5'd9, 0, 0);
        chk("single.done_len", 32'(dl0), 1);
        chk("single.done_tag", 32'(dt0), 3);
        chk("single.ack_in_done", 32'(ack0), 1);
        drive(0, 5'd0, 1, 1);
        drive(0, 5'd0, 0, 0);

        // Beats with no free core: backpressure vs discard.
        for (int c = 0; c < 5; c++) begin
            drive(0, 5'd0, 1, 0);
            chk("nogrant.sn_rdy", 32'(srdy0), 0);
        end
        drive(1, 5'd2, 1, 0);
        chk("late.ack", 32'(ack0), 1);
        chk("dropmid.ack", 32'(ack1), 0);
        drive(0, 5'd0, 1, 1);
        chk("late.wr_en", 32'(wr0), 1);
        drive(0, 5'd0, 0, 0);
        chk("late.drop_cnt", dc0, 0);
        chk("drop1.drop_cnt", dc1, 1);

        // Discarded 3-beat packet with rdy rising on beat 2.
        drive(0, 5'd0, 1, 0);
        drive(1, 5'd5, 1, 0);
        chk("drop2.ack_b2", 32'(ack1), 0);
        drive(1, 5'd5, 1, 1);
        chk("drop2.ack_b3", 32'(ack1), 0);
        drive(1, 5'd5, 0, 0);
        chk("drop2.ack_idle", 32'(ack1), 1);
        chk("drop2.drop_cnt", dc1, 2);
        drive(0, 5'd0, 1, 1);
        drive(0, 5'd0, 0, 0);

        // 20-beat packet: full count vs 4-bit saturation.
        drive(1, 5'd11, 0, 0);
        for (int b = 0; b < 20; b++) drive(0, 5'd0, 1, logic'(b == 19));
        drive(0, 5'd0, 0, 0);
        chk("long.done_len16", 32'(dl0), 20);
        chk("long.done_len4", 32'(dl2), 15);

        // Reset asserted while a packet is in flight.
        drive(1, 5'd4, 0, 0);
        for (int b = 0; b < 3; b++) drive(0, 5'd0, 1, 0);
        #1 rst = 1'b0;
        #1;
        chk("rstmid.sel_vld", 32'(sv0), 0);
        chk("rstmid.done", 32'(dn0), 0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 5'd6, 0, 0);
        chk("postrst.ack", 32'(ack0), 1);
        drive(0, 5'd0, 1, 1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            drive(logic'($urandom_range(0, 3) == 0), 5'($urandom),
                  logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/snoop_arb_ctrl.md
Name: snoop_arb_ctrl

Overview:
- Root consumer of the snoop arbiter's tag tree; sits directly downstream of the top tree node.
- Accepts the winning core tag via the rdy/ack handshake and locks that grant for exactly one snooped packet.
- Steers packet beats to the granted core, reports completion with tag and beat count, and optionally drops packets when no core is free.

Parameters:
- TAG_SZ, 5, width of core tag; matches the tag tree.
- LEN_SZ, 16, width of the per-packet beat counter; saturating.
- DROP_WHEN_NONE, 0, 1 = discard packets arriving with no grant; 0 = backpressure the snooper.
- DROP_CNT_SZ, 32, width of the dropped-packet counter; saturating.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- tag  in  TAG_SZ  winning tag from tree root.
- rdy  in  1  tree root has a free core.
- ack  out  1  consume root tag (combinational).
- sn_vld  in  1  snooper beat valid.
- sn_last  in  1  final beat of packet.
- sn_rdy  out  1  beat accepted this cycle when sn_vld also high.
- sel_tag  out  TAG_SZ  currently granted core.
- sel_vld  out  1  sel_tag is a live grant.
- wr_en  out  1  write strobe to granted core; equals sn_vld && sn_rdy && sel_vld.
- done  out  1  one-cycle completion pulse.
- done_tag  out  TAG_SZ  core that finished; valid with done.
- done_len  out  LEN_SZ  beats in finished packet; valid with done.
- drop_cnt  out  DROP_CNT_SZ  packets dropped since reset.

Behaviour:
- Reset (rst low, async): state IDLE; sel_tag=0, sel_vld=0, done=0, done_tag=0, done_len=0, drop_cnt=0, beat counter=0.
- ack = (state==IDLE) && rdy. ack is never asserted outside IDLE.
- States: IDLE, ARMED, BUSY, DROP.
- IDLE:
  - sel_vld=0.
  - If rdy: ack=1, latch tag into sel_tag, go to ARMED next cycle.
  - sn_rdy=0 when rdy=1. Any beat present waits and is accepted in ARMED.
  - Else if DROP_WHEN_NONE=1: sn_rdy=1.
    - A beat with sn_last increments drop_cnt and stays in IDLE.
    - A beat without sn_last goes to DROP.
  - Else: sn_rdy=0.
- ARMED:
  - sel_vld=1, sn_rdy=1.
  - Beat with !sn_last: counter=1, go to BUSY.
  - Beat with sn_last: done pulse next cycle with done_len=1, go to IDLE.
- BUSY:
  - sel_vld=1, sn_rdy=1.
  - Each beat increments the counter, saturating at all-ones.
  - Beat with sn_last: registered done=1 next cycle, done_tag=sel_tag, done_len=final count including the last beat, go to IDLE.
- DROP:
  - sn_rdy=1, ack=0 regardless of rdy; a grant never starts mid-packet.
  - Beat with sn_last: increment drop_cnt (saturating), go to IDLE.
- Latency: rdy → ack is 0 cycles; ack → sel_vld is 1 cycle; last beat → done is 1 cycle.
- After done, the earliest next ack is in the same cycle done is high, because state is already IDLE.
- sel_tag holds its value through IDLE until the next ack.
- sn_vld low in ARMED or BUSY: hold state; no counter change.
- Reset asserted mid-packet: immediate return to IDLE; no done pulse. The downstream core sees sel_vld fall and must discard its partial packet.
- Counter width: a packet longer than 2^LEN_SZ−1 beats reports done_len = all-ones.
- drop_cnt stays 0 when DROP_WHEN_NONE=0.

Decomposition:
- Shared package snoop_arb_pkg: state encoding constants (IDLE=2'd0, ARMED=2'd1, BUSY=2'd2, DROP=2'd3) and default TAG_SZ.
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst, clr, inc, count), instantiated for the beat counter and for drop_cnt.

Test Plan:
- rdy=1, tag=5'd7 in IDLE → ack=1 that cycle; next cycle sel_vld=1, sel_tag=7. Then a 4-beat packet with no gaps → wr_en high 4 cycles; done=1, done_tag=7, done_len=4 one cycle after last beat.
- Single-beat packet (sn_vld=sn_last=1) in ARMED with tag 3 → done_len=1, done_tag=3; ack possible in the done cycle.
- DROP_WHEN_NONE=0, rdy=0, sn_vld=1 for 5 cycles → sn_rdy=0 throughout. rdy rises with tag 2 → beat accepted in ARMED; drop_cnt stays 0.
- DROP_WHEN_NONE=1, rdy=0, 3-beat packet → drop_cnt=1. rdy asserted on beat 2 → ack=0 until last beat consumed, then ack in IDLE.
- LEN_SZ=4, 20-beat packet → done_len=15.
- rst pulled low during BUSY → sel_vld=0, done=0, state IDLE immediately. After release, the next rdy gives ack normally.
